// File: rtl/alu_seq_pkg.sv
// Shared encodings and constants for the ALU sequencer slice.
package alu_seq_pkg;

    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = 8;
    localparam int MUL_ITERS = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MUL_LOOP = 2'b01,
        ST_DONE     = 2'b10
    } state_e;

endpackage

// File: rtl/adder_subtracter_4Bit.sv
// Shared 4-bit adder-subtracter; in subtract mode the carry-out is the
// no-borrow flag (1 when a >= b).
module adder_subtracter_4Bit
    import alu_seq_pkg::*;
(
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    input  logic                 sub,
    output logic [OPERAND_W-1:0] sum,
    output logic                 carry
);

    logic [OPERAND_W-1:0] b_eff;

    // Two's-complement subtract: invert b and inject the +1 as carry-in.
    assign b_eff        = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{OPERAND_W{1'b0}}, sub};

endmodule

// File: rtl/alu_sequencer.sv
// Request/response ALU: single-cycle ADD/SUB, 4-iteration shift-add MUL.
// The multiplier is built only when ALU_SEQ_MUL_EN is defined.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [OPERAND_W-1:0] req_a,
    input  logic [OPERAND_W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RESULT_W-1:0]  rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_err
);

    state_e               state;
    op_e                  op;
    logic [OPERAND_W-1:0] add_a;
    logic [OPERAND_W-1:0] add_b;
    logic [OPERAND_W-1:0] add_sum;
    logic                 add_sub;
    logic                 add_carry;

    assign op        = op_e'(req_op);
    assign req_ready = (state == ST_IDLE);

`ifdef ALU_SEQ_MUL_EN
    logic [OPERAND_W-1:0] a_reg;
    logic [OPERAND_W-1:0] hi;
    logic [OPERAND_W-1:0] lo;
    logic [1:0]           iter;
    logic [OPERAND_W-1:0] hi_t;
    logic                 c_t;

    // Conditional add of the multiplicand before the right shift.
    always_comb begin
        hi_t = hi;
        c_t  = 1'b0;
        if (lo[0]) begin
            hi_t = add_sum;
            c_t  = add_carry;
        end
    end
`endif

    // The adder serves the request operands in IDLE and the partial product in MUL_LOOP.
    always_comb begin
        add_a   = req_a;
        add_b   = req_b;
        add_sub = (op == OP_SUB);
`ifdef ALU_SEQ_MUL_EN
        if (state == ST_MUL_LOOP) begin
            add_a   = hi;
            add_b   = a_reg;
            add_sub = 1'b0;
        end
`endif
    end

    adder_subtracter_4Bit u_addsub (
        .a     (add_a),
        .b     (add_b),
        .sub   (add_sub),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            a_reg      <= '0;
            hi         <= '0;
            lo         <= '0;
            iter       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        case (op)
                            OP_ADD, OP_SUB: begin
                                rsp_result <= {{(RESULT_W-OPERAND_W){1'b0}}, add_sum};
                                rsp_carry  <= add_carry;
                                rsp_err    <= 1'b0;
                                rsp_valid  <= 1'b1;
                                state      <= ST_DONE;
                            end
`ifdef ALU_SEQ_MUL_EN
                            OP_MUL: begin
                                a_reg <= req_a;
                                lo    <= req_b;
                                hi    <= '0;
                                iter  <= '0;
                                state <= ST_MUL_LOOP;
                            end
`endif
                            default: begin
                                rsp_result <= '0;
                                rsp_carry  <= 1'b0;
                                rsp_err    <= 1'b1;
                                rsp_valid  <= 1'b1;
                                state      <= ST_DONE;
                            end
                        endcase
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL_LOOP: begin
                    hi   <= {c_t, hi_t[OPERAND_W-1:1]};
                    lo   <= {hi_t[0], lo[OPERAND_W-1:1]};
                    iter <= iter + 2'd1;
                    // The last iteration publishes the shifted product directly.
                    if (iter == 2'(MUL_ITERS - 1)) begin
                        rsp_result <= {c_t, hi_t, lo[OPERAND_W-1:1]};
                        rsp_carry  <= 1'b0;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer against an arithmetic model;
// expectations follow ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_err;

    int n_cmp;
    int n_bad;

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lat = clock edges after the accepting edge at which rsp_valid rises.
    function automatic void model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                  output logic [7:0] r, output logic c, output logic e, output int lat);
        int s;
        r = 8'd0; c = 1'b0; e = 1'b0; lat = 0;
        case (op)
            2'b00: begin
                s = int'(a) + int'(b);
                r = 8'(s % 16);
                c = (s > 15);
            end
            2'b01: begin
                s = int'(a) - int'(b) + 16;
                r = 8'(s % 16);
                c = (a >= b);
            end
            2'b10: begin
`ifdef ALU_SEQ_MUL_EN
                r   = 8'(int'(a) * int'(b));
                lat = 4;
`else
                e = 1'b1;
`endif
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic scramble_req();
        req_valid = 1'b1;
        req_op    = 2'($urandom);
        req_a     = 4'($urandom);
        req_b     = 4'($urandom);
    endtask

    // Issues one request from IDLE, checks latency, payload, hold under stall and return to IDLE.
    task automatic run_txn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input int stall, input string tag);
        logic [7:0] er;
        logic       ec;
        logic       ee;
        int         elat;
        int         extra;
        model(op, a, b, er, ec, ee, elat);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL %s idle_ready: got %b expected 1", tag, req_ready);
        end
        @(posedge clk); #1;
        scramble_req();
        extra = 0;
        while (rsp_valid !== 1'b1 && extra < 20) begin
            n_cmp++;
            if (req_ready !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL %s busy_ready: got %b expected 0", tag, req_ready);
            end
            @(posedge clk); #1;
            scramble_req();
            extra++;
        end
        n_cmp++;
        if (extra != elat) begin
            n_bad++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", tag, extra, elat);
        end
        n_cmp++;
        if (rsp_result !== er) begin
            n_bad++;
            $display("[TB] FAIL %s result: got %h expected %h", tag, rsp_result, er);
        end
        n_cmp++;
        if ({rsp_carry, rsp_err} !== {ec, ee}) begin
            n_bad++;
            $display("[TB] FAIL %s carry_err: got %b%b expected %b%b", tag, rsp_carry, rsp_err, ec, ee);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            scramble_req();
            n_cmp++;
            if ({rsp_valid, req_ready, rsp_result, rsp_carry, rsp_err} !== {1'b1, 1'b0, er, ec, ee}) begin
                n_bad++;
                $display("[TB] FAIL %s hold[%0d]: got v=%b rdy=%b r=%h c=%b e=%b expected v=1 rdy=0 r=%h c=%b e=%b",
                         tag, i, rsp_valid, req_ready, rsp_result, rsp_carry, rsp_err, er, ec, ee);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL %s after_handshake: got v=%b rdy=%b expected v=0 rdy=1", tag, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({rsp_valid, req_ready, rsp_result, rsp_carry, rsp_err} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL reset_state: got v=%b rdy=%b r=%h c=%b e=%b expected v=0 rdy=1 r=00 c=0 e=0",
                     rsp_valid, req_ready, rsp_result, rsp_carry, rsp_err);
        end
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 4'd3;
        req_b     = 4'd4;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL reset_hold: got v=%b rdy=%b expected v=0 rdy=1", rsp_valid, req_ready);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        run_txn(2'b00, 4'd7, 4'd9, 0, "add_7_9");
        run_txn(2'b00, 4'd15, 4'd1, 1, "add_15_1");
        run_txn(2'b00, 4'd2, 4'd3, 0, "add_2_3");
    endtask

    task automatic test_sub();
        run_txn(2'b01, 4'd5, 4'd3, 0, "sub_5_3");
        run_txn(2'b01, 4'd3, 4'd5, 0, "sub_3_5");
        run_txn(2'b01, 4'd4, 4'd4, 1, "sub_4_4");
    endtask

    task automatic test_mul();
        run_txn(2'b10, 4'd15, 4'd15, 0, "mul_15_15");
        run_txn(2'b10, 4'd0, 4'd9, 0, "mul_0_9");
        run_txn(2'b10, 4'd9, 4'd1, 1, "mul_9_1");
    endtask

    task automatic test_err();
        run_txn(2'b11, 4'd12, 4'd5, 0, "op_rsv");
        run_txn(2'b11, 4'd0, 4'd0, 2, "op_rsv_stall");
    endtask

    task automatic test_backpressure();
        run_txn(2'b10, 4'd6, 4'd7, 3, "mul_6_7_bp");
        run_txn(2'b00, 4'd8, 4'd8, 3, "add_8_8_bp");
    endtask

    // Reset while busy (mid-multiply when built in, otherwise while holding a response).
    task automatic test_reset_mid();
        logic seen;
`ifdef ALU_SEQ_MUL_EN
        req_op = 2'b10;
`else
        req_op = 2'b11;
`endif
        req_valid = 1'b1;
        req_a     = 4'd15;
        req_b     = 4'd15;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, req_ready, rsp_result, rsp_carry, rsp_err} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL reset_mid: got v=%b rdy=%b r=%h c=%b e=%b expected v=0 rdy=1 r=00 c=0 e=0",
                     rsp_valid, req_ready, rsp_result, rsp_carry, rsp_err);
        end
        #2;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_no_rsp: got rsp_valid seen=%b expected 0", seen);
        end
        run_txn(2'b00, 4'd1, 4'd1, 0, "after_reset_add");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            run_txn(2'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 4'd0;
        req_b     = 4'd0;
        rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_err();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters SHALL be none; operand width is fixed at 4 bits, product width at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-006 req_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 reserved.
REQ-007 req_a  input  4  operand A.
REQ-008 req_b  input  4  operand B, or multiplier for MUL.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-011 rsp_result  output  8  result; ADD/SUB in bits [3:0] with [7:4]=0, MUL uses full 8 bits.
REQ-012 rsp_carry  output  1  ADD carry-out; SUB no-borrow (1 when A>=B); MUL 0.
REQ-013 rsp_err  output  1  unsupported opcode.

Function
REQ-014 The FSM SHALL have states IDLE, MUL_LOOP, DONE; req_ready = (state==IDLE), combinational.
REQ-015 ADD/SUB SHALL accept in IDLE, compute through the shared 4-bit adder-subtracter (SUB = req_op==01), register the result, and go to DONE: rsp_valid rises the cycle after acceptance.
REQ-016 MUL SHALL latch A and B, clear hi nibble, and enter MUL_LOOP with iteration counter 0.
REQ-017 MUL_LOOP SHALL perform one shift-add iteration per cycle using the same adder in add mode: if lo[0], {c,hi} = hi + A, else c=0, hi unchanged; then {c,hi,lo} shifts right by 1.
REQ-018 MUL_LOOP SHALL exit to DONE after exactly 4 iterations: rsp_valid rises 4 cycles after acceptance; rsp_result = {hi,lo}.
REQ-019 Opcode 11 (and 10 when multiply is compiled out) SHALL go to DONE with rsp_result=0, rsp_carry=0, rsp_err=1, one-cycle latency.
REQ-020 DONE SHALL hold rsp_valid and all rsp_* stable until rsp_ready; on handshake, return to IDLE, with rsp_valid low the following cycle.
REQ-021 Requests SHALL NOT be accepted in MUL_LOOP or DONE; back-to-back throughput is one bubble cycle per response.
REQ-022 req_* inputs SHALL be sampled only at acceptance; later changes have no effect.
REQ-023 ADD/SUB wrap-around SHALL be modulo 16, with overflow reported only through rsp_carry.

Reset
REQ-024 Asserting rst_n low SHALL immediately force state IDLE, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_err=0, and clear operand, product and counter registers.
REQ-025 Reset mid-MUL_LOOP or mid-DONE SHALL discard the operation; no response is produced after release.

Configuration
REQ-026 Macro ALU_SEQ_MUL_EN defined: MUL_LOOP state, product registers and iteration counter are compiled in, and opcode 10 performs the multiply.
REQ-027 Macro ALU_SEQ_MUL_EN undefined: MUL_LOOP logic is absent and opcode 10 SHALL return an rsp_err response per REQ-019.

Structure
REQ-028 Package alu_seq_pkg SHALL hold the opcode encodings, FSM state encodings, and the constants OPERAND_W=4 and MUL_ITERS=4.
REQ-029 The shared arithmetic SHALL be a single instantiated adder_subtracter_4Bit sub-module; no other adder is permitted.

Verification
REQ-030 Reset: rst_n low during MUL_LOOP -> rsp_valid=0 and req_ready=1 immediately; no response after release.
REQ-031 ADD 7+9 -> rsp_valid 1 cycle later; result 0x00, carry=1, err=0.
REQ-032 SUB 5-3 -> 0x02, carry=1; SUB 3-5 -> 0x0E, carry=0.
REQ-033 MUL 15*15 -> rsp_valid exactly 4 cycles after acceptance; result 0xE1, carry=0; MUL 0*9 -> 0x00.
REQ-034 Backpressure: rsp_ready low for 3 cycles after MUL 6*7 -> 0x2A held stable, req_ready=0 throughout; handshake -> IDLE next cycle.
REQ-035 Opcode 11, and opcode 10 built without ALU_SEQ_MUL_EN -> err=1, result 0x00, 1-cycle latency.
